// File: rtl/page_table_32b_if.sv
// Lookup and entry-write bus for the 16-entry page table that backs the TLB.
// The master issues translation requests and writes; the slave is the table.
interface page_table_32b_if;
    logic        LOOKUP_RQST;
    logic [3:0]  LOOKUP_ADDR;
    logic        LOOKUP_COMPLETE;
    logic [7:0]  LOOKUP_RETURN;
    logic        LOOKUP_FAULT;
    logic        BUSY;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [15:0] WR_DATA;

    modport master (
        output LOOKUP_RQST,
        output LOOKUP_ADDR,
        input  LOOKUP_COMPLETE,
        input  LOOKUP_RETURN,
        input  LOOKUP_FAULT,
        input  BUSY,
        output WR_EN,
        output WR_ADDR,
        output WR_DATA
    );

    modport slave (
        input  LOOKUP_RQST,
        input  LOOKUP_ADDR,
        output LOOKUP_COMPLETE,
        output LOOKUP_RETURN,
        output LOOKUP_FAULT,
        output BUSY,
        input  WR_EN,
        input  WR_ADDR,
        input  WR_DATA
    );
endinterface

// File: rtl/page_table_32b.sv
// 16 x 16-bit page table: one translation at a time after a fixed walk latency,
// with a write port for reprogramming entries. All outputs are registered.
module page_table_32b #(
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    page_table_32b_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  addr_q, addr_d;
    logic        complete_q, complete_d;
    logic        fault_q, fault_d;
    logic        busy_q, busy_d;
    logic [7:0]  return_q, return_d;
    logic [15:0] table_q [16];
    logic [15:0] table_d [16];

    // Writes land at the edge; the walk reads table_q, so a same-edge write is not seen.
    always_comb begin
        table_d = table_q;
        if (bus.WR_EN) begin
            table_d[bus.WR_ADDR] = bus.WR_DATA;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        complete_d = 1'b0;
        fault_d    = 1'b0;
        return_d   = return_q;
        unique case (state_q)
            IDLE: begin
                if (bus.LOOKUP_RQST) begin
                    addr_d  = bus.LOOKUP_ADDR;
                    cnt_d   = CNT_LOAD;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = DONE;
                    complete_d = 1'b1;
                    fault_d    = ~table_q[addr_q][15];
                    return_d   = table_q[addr_q][15] ? table_q[addr_q][7:0] : 8'h00;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset reloads the identity-style table and abandons any walk in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 4'd0;
            complete_q <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            return_q   <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                table_q[i] <= {1'b1, 7'b0, ~4'(i), 4'(i)};
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            complete_q <= complete_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
            return_q   <= return_d;
            table_q    <= table_d;
        end
    end

    assign bus.LOOKUP_COMPLETE = complete_q;
    assign bus.LOOKUP_FAULT    = fault_q;
    assign bus.LOOKUP_RETURN   = return_q;
    assign bus.BUSY            = busy_q;

endmodule

// File: tb/tb_page_table_32b.sv
// Directed bench for page_table_32b: latency, back-to-back requests, faults,
// ignored mid-walk inputs, reset mid-walk and read-before-write on the read edge.
module tb_page_table_32b;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    page_table_32b_if bus ();

    page_table_32b #(.LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic rqst, input logic [3:0] addr,
                                  input logic wr_en, input logic [3:0] wr_addr,
                                  input logic [15:0] wr_data);
        bus.LOOKUP_RQST = rqst;
        bus.LOOKUP_ADDR = addr;
        bus.WR_EN       = wr_en;
        bus.WR_ADDR     = wr_addr;
        bus.WR_DATA     = wr_data;
        tick();
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Full lookup with a one-cycle request pulse and exact-cycle checks.
    task automatic do_lookup(input string tag, input logic [3:0] addr,
                             input logic [7:0] exp_ret, input logic exp_fault);
        apply_stimulus(1'b1, addr, 1'b0, 4'h0, 16'h0000);
        check_output({tag, "_busy_e0"}, 16'(bus.BUSY), 16'h1);
        apply_stimulus(1'b0, addr, 1'b0, 4'h0, 16'h0000);
        tick();
        tick();
        check_output({tag, "_cmp_e3"}, 16'(bus.LOOKUP_COMPLETE), 16'h0);
        tick();
        check_output({tag, "_cmp_e4"}, 16'(bus.LOOKUP_COMPLETE), 16'h1);
        check_output({tag, "_ret"}, 16'(bus.LOOKUP_RETURN), 16'(exp_ret));
        check_output({tag, "_fault"}, 16'(bus.LOOKUP_FAULT), 16'(exp_fault));
        tick();
        check_output({tag, "_cmp_e5"}, 16'(bus.LOOKUP_COMPLETE), 16'h0);
        check_output({tag, "_busy_e5"}, 16'(bus.BUSY), 16'h0);
    endtask

    initial begin
        int pulses;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.LOOKUP_RQST = 1'b0;
        bus.LOOKUP_ADDR = 4'h0;
        bus.WR_EN       = 1'b0;
        bus.WR_ADDR     = 4'h0;
        bus.WR_DATA     = 16'h0000;

        tick();
        tick();
        check_output("rst_complete", 16'(bus.LOOKUP_COMPLETE), 16'h0);
        check_output("rst_fault", 16'(bus.LOOKUP_FAULT), 16'h0);
        check_output("rst_return", 16'(bus.LOOKUP_RETURN), 16'h00);
        check_output("rst_busy", 16'(bus.BUSY), 16'h0);
        rst = 1'b0;

        // Single lookup of entry 0, then the return value must hold.
        do_lookup("t1", 4'h0, 8'hF0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_output("t1_hold", 16'(bus.LOOKUP_RETURN), 16'h00F0);

        // Request held high: accepts at E0 and E6, completions at E4 and E10.
        apply_stimulus(1'b1, 4'h3, 1'b0, 4'h0, 16'h0000);
        bus.LOOKUP_ADDR = 4'h9;
        for (int i = 0; i < 3; i++) tick();
        check_output("t2_cmp_e3", 16'(bus.LOOKUP_COMPLETE), 16'h0);
        tick();
        check_output("t2_cmp_e4", 16'(bus.LOOKUP_COMPLETE), 16'h1);
        check_output("t2_ret1", 16'(bus.LOOKUP_RETURN), 16'h00C3);
        tick();
        check_output("t2_cmp_e5", 16'(bus.LOOKUP_COMPLETE), 16'h0);
        check_output("t2_busy_e5", 16'(bus.BUSY), 16'h0);
        tick();
        check_output("t2_busy_e6", 16'(bus.BUSY), 16'h1);
        for (int i = 0; i < 3; i++) tick();
        check_output("t2_cmp_e9", 16'(bus.LOOKUP_COMPLETE), 16'h0);
        tick();
        check_output("t2_cmp_e10", 16'(bus.LOOKUP_COMPLETE), 16'h1);
        check_output("t2_ret2", 16'(bus.LOOKUP_RETURN), 16'h0069);
        bus.LOOKUP_RQST = 1'b0;
        tick();
        check_output("t2_cmp_e11", 16'(bus.LOOKUP_COMPLETE), 16'h0);
        tick();

        // Invalid entry faults; rewriting it valid returns the new frame.
        apply_stimulus(1'b0, 4'h0, 1'b1, 4'h5, 16'h0012);
        do_lookup("t3a", 4'h5, 8'h00, 1'b1);
        apply_stimulus(1'b0, 4'h0, 1'b1, 4'h5, 16'h80AB);
        do_lookup("t3b", 4'h5, 8'hAB, 1'b0);

        // Address change and request toggle mid-walk are ignored.
        apply_stimulus(1'b1, 4'h7, 1'b0, 4'h0, 16'h0000);
        apply_stimulus(1'b0, 4'h7, 1'b0, 4'h0, 16'h0000);
        apply_stimulus(1'b1, 4'hE, 1'b0, 4'h0, 16'h0000);
        apply_stimulus(1'b0, 4'hE, 1'b0, 4'h0, 16'h0000);
        tick();
        check_output("t4_cmp_e4", 16'(bus.LOOKUP_COMPLETE), 16'h1);
        check_output("t4_ret", 16'(bus.LOOKUP_RETURN), 16'h0087);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.LOOKUP_COMPLETE === 1'b1) pulses++;
        end
        check_output("t4_no_second", 16'(pulses), 16'h0);

        // Reset mid-walk discards the lookup and restores the table.
        apply_stimulus(1'b1, 4'h2, 1'b0, 4'h0, 16'h0000);
        apply_stimulus(1'b0, 4'h2, 1'b0, 4'h0, 16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t5_busy", 16'(bus.BUSY), 16'h0);
        check_output("t5_return", 16'(bus.LOOKUP_RETURN), 16'h0000);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.LOOKUP_COMPLETE === 1'b1) pulses++;
        end
        check_output("t5_no_pulse", 16'(pulses), 16'h0);
        do_lookup("t5", 4'h5, 8'hA5, 1'b0);

        // Write on the read edge: old value returned, new value seen next time.
        apply_stimulus(1'b1, 4'h1, 1'b0, 4'h0, 16'h0000);
        apply_stimulus(1'b0, 4'h1, 1'b0, 4'h0, 16'h0000);
        tick();
        tick();
        apply_stimulus(1'b0, 4'h1, 1'b1, 4'h1, 16'h8055);
        check_output("t6_cmp", 16'(bus.LOOKUP_COMPLETE), 16'h1);
        check_output("t6_old", 16'(bus.LOOKUP_RETURN), 16'h00E1);
        apply_stimulus(1'b0, 4'h1, 1'b0, 4'h0, 16'h0000);
        do_lookup("t6", 4'h1, 8'h55, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
